// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state, owner encodings and the word funct3 used for instruction fetches
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_WAIT, ARB_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;
  localparam logic [2:0] FUNCT3_WORD = 3'b010;
endpackage

// File: rtl/arb_lat_counter.sv
// arb_lat_counter: loadable down-counter (clk, rst, load, value) flagging last when the count is 1
module arb_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign last = cnt == W'(1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin IF/DM arbiter for one fixed-latency memory; requesters if_*/dm_*, memory mem_*, stalls stall_if/stall_dm; ARB_PERF_CNT_EN adds if_wait_cnt/dm_wait_cnt/conflict_cnt
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_funct3,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_dm
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       if_wait_cnt,
  output logic [31:0]       dm_wait_cnt,
  output logic [31:0]       conflict_cnt
`endif
);
  localparam int CW = $clog2(MEM_LAT + 1);
  arb_state_t state, state_nx;
  arb_owner_t owner, last_grant;
  logic grant, grant_dm, cnt_last, op_we;
  // rst gates the strobe so nothing is issued in the reset cycle itself
  assign grant    = state == ARB_IDLE && (if_req || dm_req) && !rst;
  assign grant_dm = dm_req && (!if_req || last_grant == OWN_IF);
  arb_lat_counter #(.W(CW)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (grant),
    .value(CW'(MEM_LAT)),
    .last (cnt_last)
  );
  always_comb begin
    mem_en     = grant;
    mem_we     = grant && grant_dm && dm_we;
    mem_addr   = grant ? (grant_dm ? dm_addr : if_addr) : '0;
    mem_wdata  = mem_we ? dm_wdata : '0;
    mem_funct3 = grant ? (grant_dm ? dm_funct3 : FUNCT3_WORD) : '0;
    state_nx   = state == ARB_IDLE ? (if_req || dm_req ? ARB_WAIT : ARB_IDLE) :
                 state == ARB_WAIT ? (cnt_last ? ARB_RESP : ARB_WAIT) : ARB_IDLE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      last_grant <= OWN_IF;
      op_we      <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner      <= grant_dm ? OWN_DM : OWN_IF;
        last_grant <= grant_dm ? OWN_DM : OWN_IF;
        op_we      <= grant_dm && dm_we;
      end
      if (state == ARB_WAIT && cnt_last && owner == OWN_IF) if_rdata <= mem_rdata;
      if (state == ARB_WAIT && cnt_last && owner == OWN_DM && !op_we) dm_rdata <= mem_rdata;
    end
  assign if_valid = state == ARB_RESP && owner == OWN_IF;
  assign dm_valid = state == ARB_RESP && owner == OWN_DM;
  assign stall_if = if_req && !if_valid;
  assign stall_dm = dm_req && !dm_valid;
`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk)
    if (rst) begin
      if_wait_cnt  <= '0;
      dm_wait_cnt  <= '0;
      conflict_cnt <= '0;
    end else begin
      if (stall_if && !(&if_wait_cnt)) if_wait_cnt <= if_wait_cnt + 1'b1;
      if (stall_dm && !(&dm_wait_cnt)) dm_wait_cnt <= dm_wait_cnt + 1'b1;
      if (state == ARB_IDLE && if_req && dm_req && !(&conflict_cnt)) conflict_cnt <= conflict_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and randomized model check of mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [2:0]  dm_funct3 = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, dm_valid, mem_en, mem_we, stall_if, stall_dm;
  logic [2:0]  mem_funct3;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_valid1, dm_valid1, mem_en1, mem_we1, stall_if1, stall_dm1;
  logic [2:0]  mem_funct31;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] if_wait_cnt, dm_wait_cnt, conflict_cnt, if_wait_cnt1, dm_wait_cnt1, conflict_cnt1;
`endif
  int n_vec = 0, n_bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_funct3(dm_funct3),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_dm(stall_dm)
`ifdef ARB_PERF_CNT_EN
    , .if_wait_cnt(if_wait_cnt), .dm_wait_cnt(dm_wait_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_valid(if_valid1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_funct3(dm_funct3),
    .dm_rdata(dm_rdata1), .dm_valid(dm_valid1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_funct3(mem_funct31), .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_dm(stall_dm1)
`ifdef ARB_PERF_CNT_EN
    , .if_wait_cnt(if_wait_cnt1), .dm_wait_cnt(dm_wait_cnt1), .conflict_cnt(conflict_cnt1)
`endif
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a == 32'h10 ? 32'h00500093 : a == 32'h100 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h00005A5A;
  endfunction

  // memory models: read data is only correct in the exact cycle MEM_LAT after the strobe
  logic [2:0]  t0 = '0, t1 = '0;
  logic [31:0] a0 = '0, a1 = '0;
  always @(posedge clk)
    if (rst) t0 <= '0;
    else if (mem_en && !mem_we) begin t0 <= 3'(LAT); a0 <= mem_addr; end
    else if (t0 != 0) t0 <= t0 - 1'b1;
  always @(posedge clk)
    if (rst) t1 <= '0;
    else if (mem_en1 && !mem_we1) begin t1 <= 3'd1; a1 <= mem_addr1; end
    else if (t1 != 0) t1 <= t1 - 1'b1;
  assign mem_rdata  = t0 == 1 ? mem_f(a0) : 32'hBADC0FFE;
  assign mem_rdata1 = t1 == 1 ? mem_f(a1) : 32'hBADC0FFE;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_req = 0; dm_we = 0; if_addr = '0; dm_addr = '0; dm_wdata = '0; dm_funct3 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; if_req = 1; if_addr = 32'h10;
    tick();
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_dm_valid", dm_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_mem_en_lat1", mem_en1, 0);
    tick();
    rst = 0;
    idle_inputs();
  endtask

  typedef struct {
    logic ifr; logic [31:0] ia; logic dmr; logic we; logic [31:0] da; logic [31:0] wd; logic [2:0] f3;
    logic e_en; logic e_we; logic [31:0] e_addr; logic [31:0] e_wd; logic [2:0] e_f3;
    logic e_iv; logic e_dv; logic e_si; logic e_sd; logic [31:0] e_ird; logic [31:0] e_drd;
  } vec_t;
  vec_t tbl [15];

  initial begin
    int free_at, resp_at;
    logic own_dm, last_dm, ld, g_dm, ev_if, ev_dm;
    logic [31:0] dat, eird, edrd;
    tbl[0]  = '{1, 32'h10, 0, 0, 0, 0, 0,   1, 0, 32'h10, 0, 3'b010,  0, 0, 1, 0, 0, 0};
    tbl[1]  = '{1, 32'h10, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 32'h10, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,            0, 0, 1, 0, 0, 0};
    tbl[3]  = '{1, 32'h10, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0,            1, 0, 0, 0, 32'h00500093, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0,            0, 0, 0, 0, 32'h00500093, 0};
    tbl[5]  = '{0, 0, 1, 0, 32'h100, 0, 4,  1, 0, 32'h100, 0, 3'b100, 0, 0, 0, 1, 32'h00500093, 0};
    tbl[6]  = '{0, 0, 1, 0, 32'h100, 0, 4,  0, 0, 0, 0, 0,            0, 0, 0, 1, 32'h00500093, 0};
    tbl[7]  = '{0, 0, 1, 0, 32'h100, 0, 4,  0, 0, 0, 0, 0,            0, 0, 0, 1, 32'h00500093, 0};
    tbl[8]  = '{0, 0, 1, 0, 32'h100, 0, 4,  0, 0, 0, 0, 0,            0, 1, 0, 0, 32'h00500093, 32'hDEADBEEF};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0,            0, 0, 0, 0, 32'h00500093, 32'hDEADBEEF};
    tbl[10] = '{0, 0, 1, 1, 32'h20, 32'h12345678, 0, 1, 1, 32'h20, 32'h12345678, 3'b000, 0, 0, 0, 1, 32'h00500093, 32'hDEADBEEF};
    tbl[11] = '{0, 0, 1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 32'h00500093, 32'hDEADBEEF};
    tbl[12] = '{0, 0, 1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 32'h00500093, 32'hDEADBEEF};
    tbl[13] = '{0, 0, 1, 1, 32'h20, 32'h12345678, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 32'h00500093, 32'hDEADBEEF};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0,            0, 0, 0, 0, 32'h00500093, 32'hDEADBEEF};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      if_req = tbl[i].ifr; if_addr = tbl[i].ia; dm_req = tbl[i].dmr; dm_we = tbl[i].we;
      dm_addr = tbl[i].da; dm_wdata = tbl[i].wd; dm_funct3 = tbl[i].f3;
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_en", i), mem_en, tbl[i].e_en);
      chk($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
      if (tbl[i].e_en) chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      if (tbl[i].e_en) chk($sformatf("tbl%0d_mem_funct3", i), mem_funct3, tbl[i].e_f3);
      if (tbl[i].e_we) chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].e_wd);
      chk($sformatf("tbl%0d_if_valid", i), if_valid, tbl[i].e_iv);
      chk($sformatf("tbl%0d_dm_valid", i), dm_valid, tbl[i].e_dv);
      chk($sformatf("tbl%0d_stall_if", i), stall_if, tbl[i].e_si);
      chk($sformatf("tbl%0d_stall_dm", i), stall_dm, tbl[i].e_sd);
      chk($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].e_ird);
      chk($sformatf("tbl%0d_dm_rdata", i), dm_rdata, tbl[i].e_drd);
      tick();
    end

    do_reset();
    if_req = 1; if_addr = 32'h40; dm_req = 1; dm_we = 0; dm_addr = 32'h100; dm_funct3 = 3'b010;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_mem_en", c), mem_en, c % 4 == 0);
      if (c % 4 == 0) chk($sformatf("rr%0d_mem_addr", c), mem_addr, (c / 4) % 2 == 0 ? 32'h100 : 32'h40);
      chk($sformatf("rr%0d_dm_valid", c), dm_valid, c % 8 == 3);
      chk($sformatf("rr%0d_if_valid", c), if_valid, c % 8 == 7);
      chk($sformatf("rr%0d_stall_if", c), stall_if, c % 8 != 7);
      if (c == 3) chk("rr_dm_rdata", dm_rdata, 32'hDEADBEEF);
      if (c == 7) chk("rr_if_rdata", if_rdata, mem_f(32'h40));
      tick();
    end

    do_reset();
    free_at = 0; resp_at = -1; last_dm = 0; own_dm = 0; ld = 0; eird = '0; edrd = '0;
    for (int n = 0; n < 400; n++) begin
      if_req = $urandom_range(0, 2) != 0; dm_req = $urandom_range(0, 2) != 0; dm_we = 1'($urandom_range(0, 1));
      if_addr = $urandom & 32'h0000_0FFC; dm_addr = $urandom; dm_wdata = $urandom; dm_funct3 = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (n >= free_at && (if_req || dm_req)) begin
        g_dm = dm_req && (!if_req || !last_dm);
        chk($sformatf("rnd%0d_mem_en", n), mem_en, 1);
        chk($sformatf("rnd%0d_mem_we", n), mem_we, g_dm && dm_we);
        chk($sformatf("rnd%0d_mem_addr", n), mem_addr, g_dm ? dm_addr : if_addr);
        chk($sformatf("rnd%0d_mem_funct3", n), mem_funct3, g_dm ? dm_funct3 : 3'b010);
        if (g_dm && dm_we) chk($sformatf("rnd%0d_mem_wdata", n), mem_wdata, dm_wdata);
        own_dm = g_dm; ld = !(g_dm && dm_we); dat = mem_f(g_dm ? dm_addr : if_addr);
        resp_at = n + LAT + 1; free_at = n + LAT + 2; last_dm = g_dm;
      end else begin
        chk($sformatf("rnd%0d_mem_en", n), mem_en, 0);
        chk($sformatf("rnd%0d_mem_we", n), mem_we, 0);
      end
      ev_if = n == resp_at && !own_dm;
      ev_dm = n == resp_at && own_dm;
      if (n == resp_at && ld && own_dm) edrd = dat;
      if (n == resp_at && ld && !own_dm) eird = dat;
      chk($sformatf("rnd%0d_if_valid", n), if_valid, ev_if);
      chk($sformatf("rnd%0d_dm_valid", n), dm_valid, ev_dm);
      chk($sformatf("rnd%0d_if_rdata", n), if_rdata, eird);
      chk($sformatf("rnd%0d_dm_rdata", n), dm_rdata, edrd);
      chk($sformatf("rnd%0d_stall_if", n), stall_if, if_req && !ev_if);
      chk($sformatf("rnd%0d_stall_dm", n), stall_dm, dm_req && !ev_dm);
      tick();
    end

    idle_inputs();
    repeat (LAT + 3) tick();
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk("rmid_grant", mem_en, 1);
    tick();
    rst = 1;
    @(negedge clk);
    chk("rmid_mem_en_in_rst", mem_en, 0);
    tick();
    rst = 0; if_req = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) chk("rmid_mem_en", mem_en, 0);
      if (c == 0) chk("rmid_if_rdata", if_rdata, 0);
      chk($sformatf("rmid%0d_if_valid", c), if_valid, 0);
      tick();
    end

    do_reset();
    for (int c = 0; c < 7; c++) begin
      if_req = c < 6; if_addr = c < 3 ? 32'h0 : 32'h4;
      @(negedge clk);
      chk($sformatf("lat1_%0d_mem_en", c), mem_en1, c == 0 || c == 3);
      if (c == 0 || c == 3) chk($sformatf("lat1_%0d_mem_addr", c), mem_addr1, c == 0 ? 32'h0 : 32'h4);
      chk($sformatf("lat1_%0d_if_valid", c), if_valid1, c == 2 || c == 5);
      if (c == 2) chk("lat1_if_rdata0", if_rdata1, mem_f(32'h0));
      if (c == 5) chk("lat1_if_rdata4", if_rdata1, mem_f(32'h4));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
